lfsr_checker: RTL and testbench

Receive-side companion to the team's 8-bit LFSR generator. Consumes a stream of 8-bit LFSR values with a valid strobe, self-synchronises to the sequence defined by the same `taps` word, and flags every received value that deviates from the predicted sequence. Sits at the sink of a PRBS link or loopback path and provides lock status plus a saturating error counter for link qualification.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_checker.sv | 133 +++++++++++++
 tb/tb_lfsr_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the 8-bit LFSR generator/checker pair:
//               checker state type and the bit-exact next-value function.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Shift right, inserting the feedback bit at the MSB. Bit 7 of taps has no
  // partner bit and is ignored.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur,
                                           input logic [7:0] taps);
    logic fb;
    fb = cur[0];
    for (int i = 0; i < 7; i++) begin
      fb = fb ^ (taps[i] & cur[7-i]);
    end
    return {fb, cur[7:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Self-synchronising receive checker for the 8-bit LFSR stream.
//               Seeds from the stream, locks after LOCK_COUNT matches, then
//               flywheels and counts mismatches until UNLOCK_COUNT in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             in_clk,
  input  logic             in_n_rst,
  input  logic [7:0]       taps,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       expected
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] c_GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] c_MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);

  state_e             state_q;
  logic [GOOD_W-1:0]  good_q;
  logic [MISS_W-1:0]  miss_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [CNT_W-1:0]   err_count_q;
  logic [7:0]         expected_q;

  logic [7:0]         w_next_exp;
  logic [7:0]         w_next_seed;
  logic               w_match;
  logic               w_seed_ok;

  assign w_next_exp  = lfsr_next(expected_q, taps);
  assign w_next_seed = lfsr_next(in_data, taps);
  assign w_match     = (in_data == expected_q);
  assign w_seed_ok   = (in_data != 8'h00);

  // Sequence tracking FSM, match/miss counters and error accounting.
  always_ff @(posedge in_clk or negedge in_n_rst) begin
    if (!in_n_rst) begin
      state_q     <= ST_HUNT;
      good_q      <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      expected_q  <= 8'h00;
    end else if (clear) begin
      // Clear wins over a coincident sample, which is dropped.
      state_q     <= ST_HUNT;
      good_q      <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          ST_HUNT: begin
            // An all-zero value is the LFSR lock-up state and cannot seed.
            if (w_seed_ok) begin
              expected_q <= w_next_seed;
              good_q     <= '0;
              state_q    <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (w_match) begin
              expected_q <= w_next_exp;
              good_q     <= good_q + GOOD_W'(1);
              if (good_q == c_GOOD_LAST) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              good_q <= '0;
              if (w_seed_ok) begin
                expected_q <= w_next_seed;
              end else begin
                state_q <= ST_HUNT;
              end
            end
          end
          ST_LOCKED: begin
            // Flywheel: the prediction advances whether or not it matched.
            expected_q <= w_next_exp;
            if (w_match) begin
              miss_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_q <= err_count_q + CNT_W'(1);
              end
              if (miss_q == c_MISS_LAST) begin
                state_q  <= ST_HUNT;
                locked_q <= 1'b0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + MISS_W'(1);
              end
            end
          end
          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Self-checking bench for lfsr_checker: behavioural reference
//               model compared every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [7:0]       taps;
  logic             clear;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [7:0]       expected;

  int checks = 0;
  int errors = 0;

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(CNT_W)) dut (
    .in_clk    (clk),
    .in_n_rst  (rst_n),
    .taps      (taps),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent next-value: feedback is the parity of c[0] and the tapped
  // mirrored bits.
  function automatic logic [7:0] ref_next(input logic [7:0] c, input logic [7:0] t);
    int ones;
    ones = c[0] ? 1 : 0;
    for (int i = 0; i < 7; i++) if (t[i] && c[7-i]) ones++;
    return {ones[0], c[7:1]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;   // 0 hunting, 1 syncing, 2 locked
  int          m_good, m_miss;
  int          m_cnt;
  logic        m_pulse;
  logic [7:0]  m_exp;
  bit          m_exp_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
      m_exp = 8'h00; m_exp_known = 1;
    end else if (clear) begin
      m_mode = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
      m_exp_known = 0;
    end else begin
      m_pulse = 0;
      if (in_valid) begin
        if (m_mode == 0 || (m_mode == 1 && in_data != m_exp)) begin
          m_good = 0;
          if (in_data != 0) begin
            m_exp = ref_next(in_data, taps); m_exp_known = 1; m_mode = 1;
          end else begin
            m_mode = 0;
          end
        end else if (m_mode == 1) begin
          m_exp = ref_next(m_exp, taps);
          m_good++;
          if (m_good >= 4) begin m_mode = 2; m_miss = 0; end
        end else begin
          if (in_data == m_exp) m_miss = 0;
          else begin
            m_pulse = 1;
            if (m_cnt < 65535) m_cnt++;
            m_miss++;
            if (m_miss >= 3) begin m_mode = 0; m_miss = 0; end
          end
          m_exp = ref_next(m_exp, taps);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the sampling edge.
  always @(negedge clk) begin
    check("model_locked", locked, (m_mode == 2) ? 1 : 0);
    check("model_err_pulse", err_pulse, m_pulse);
    check("model_err_count", err_count, m_cnt);
    if (m_exp_known) check("model_expected", expected, m_exp);
  end

  // ---------------- stimulus ----------------
  logic [7:0] gen;

  task automatic send(input logic c, input logic v, input logic [7:0] d);
    clear = c; in_valid = v; in_data = d;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic seq_good();
    send(1'b0, 1'b1, gen);
    gen = ref_next(gen, taps);
  endtask

  task automatic seq_bad();
    send(1'b0, 1'b1, gen ^ 8'h01);
    gen = ref_next(gen, taps);
  endtask

  task automatic lock_up();
    gen = 8'hAA;
    repeat (5) seq_good();
  endtask

  initial begin
    taps = 8'hB8; clear = 0; in_valid = 0; in_data = 0; rst_n = 0;
    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      clear = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
    end
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_expected", expected, 8'h00);
    clear = 0; in_valid = 0;
    rst_n = 1;
    @(negedge clk);

    // Lock on 0xAA, 0xD5, 0xEA, 0xF5, 0xFA.
    gen = 8'hAA;
    repeat (4) seq_good();
    check("lock_not_yet", locked, 0);
    seq_good();
    check("lock_locked", locked, 1);
    check("lock_expected", expected, 8'h7D);
    check("lock_err_count", err_count, 0);

    // Single error, flywheel keeps the sequence.
    seq_bad();
    check("err1_pulse", err_pulse, 1);
    check("err1_count", err_count, 1);
    check("err1_locked", locked, 1);
    check("err1_expected", expected, 8'h3E);
    seq_good();
    check("err1_pulse_drop", err_pulse, 0);
    seq_good();
    check("err1_count_hold", err_count, 1);

    // Valid gaps hold the prediction.
    repeat (3) send(1'b0, 1'b0, 8'h55);
    check("gap_expected", expected, 8'h4F);
    check("gap_pulse", err_pulse, 0);
    seq_good();
    seq_good();
    check("gap_resume_count", err_count, 1);

    // Loss of lock after three consecutive mismatches.
    send(1'b1, 1'b0, 8'h00);
    check("clr_count", err_count, 0);
    lock_up();
    seq_bad(); seq_bad();
    check("loss_still_locked", locked, 1);
    seq_bad();
    check("loss_count", err_count, 3);
    check("loss_locked", locked, 0);
    send(1'b0, 1'b1, 8'hAA);
    check("resync_expected", expected, 8'hD5);
    check("resync_locked", locked, 0);

    // Zero values: mismatch to HUNT, then zero ignored, then reseed.
    send(1'b0, 1'b1, 8'h00);
    send(1'b0, 1'b1, 8'h00);
    send(1'b0, 1'b1, 8'hD5);
    check("zero_reseed_expected", expected, 8'hEA);

    // Clear coincident with valid while locked with five errors.
    send(1'b1, 1'b0, 8'h00);
    lock_up();
    repeat (4) begin seq_bad(); seq_good(); end
    seq_bad();
    check("five_count", err_count, 5);
    check("five_locked", locked, 1);
    send(1'b1, 1'b1, gen);
    gen = ref_next(gen, taps);
    check("clrv_count", err_count, 0);
    check("clrv_locked", locked, 0);
    check("clrv_pulse", err_pulse, 0);
    send(1'b0, 1'b1, 8'hAA);
    check("clrv_reseed", expected, 8'hD5);

    // Asynchronous reset mid-operation.
    send(1'b1, 1'b0, 8'h00);
    lock_up();
    seq_bad();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_pulse", err_pulse, 0);
    check("arst_count", err_count, 0);
    check("arst_expected", expected, 8'h00);
    @(negedge clk);
    rst_n = 1;
    send(1'b0, 1'b1, 8'hAA);
    check("arst_seed", expected, 8'hD5);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
